// File: rtl/calc1_req_sequencer.sv
// calc1 request sequencer: queues requests and drives calc1
// one operation at a time, returning its response.
module calc1_req_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  parameter int TMO_W      = 7
) (
  input  logic        c_clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:3]  req_cmd,
  input  logic [0:31] req_op1,
  input  logic [0:31] req_op2,
  output logic [0:3]  cmd_in,
  output logic [0:31] data_in,
  input  logic [0:1]  out_resp,
  input  logic [0:31] out_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:1]  rsp_code,
  output logic [0:31] rsp_data,
  output logic        busy,
  output logic        tmo_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    SEND1,
    SEND2,
    WAIT,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [0:3]  q_cmd [FIFO_DEPTH];
  logic [0:31] q_op1 [FIFO_DEPTH];
  logic [0:31] q_op2 [FIFO_DEPTH];

  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;

  logic [0:3]  cur_cmd;
  logic [0:31] cur_op1, cur_op2;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             cnt_clr, cap_rsp, cap_tmo;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = req_valid && !full;

  assign req_ready = !full;
  assign rsp_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE) || !empty;
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Request storage; contents are only meaningful between pointers
  always_ff @(posedge c_clk) begin
    if (push) begin
      q_cmd[wr_ptr[AW-1:0]] <= req_cmd;
      q_op1[wr_ptr[AW-1:0]] <= req_op1;
      q_op2[wr_ptr[AW-1:0]] <= req_op2;
    end
  end

  // FIFO pointers with wrap bit
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // State register
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, pop decision and calc1 drive
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cmd_in  = '0;
    data_in = '0;
    cnt_clr = 1'b0;
    cap_rsp = 1'b0;
    cap_tmo = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SEND1;
        end
      end
      SEND1: begin
        cmd_in  = cur_cmd;
        data_in = cur_op1;
        state_d = SEND2;
      end
      SEND2: begin
        data_in = cur_op2;
        cnt_clr = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (out_resp != 2'd0) begin
          cap_rsp = 1'b1;
          state_d = HOLD;
        end else if (tmo_hit) begin
          cap_tmo = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = SEND1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the popped request for the two send cycles
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_cmd <= '0;
      cur_op1 <= '0;
      cur_op2 <= '0;
    end else if (pop) begin
      cur_cmd <= q_cmd[rd_ptr[AW-1:0]];
      cur_op1 <= q_op1[rd_ptr[AW-1:0]];
      cur_op2 <= q_op2[rd_ptr[AW-1:0]];
    end
  end

  // Response wait counter, restarted while sending operand 2
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n)               tmo_cnt <= '0;
    else if (cnt_clr)           tmo_cnt <= '0;
    else if (state_q == WAIT)   tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Captured response and sticky timeout flag
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_code <= '0;
      rsp_data <= '0;
      tmo_err  <= 1'b0;
    end else if (cap_rsp) begin
      rsp_code <= out_resp;
      rsp_data <= out_data;
    end else if (cap_tmo) begin
      rsp_code <= '0;
      rsp_data <= '0;
      tmo_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc1_req_sequencer.sv
// Directed bench for calc1_req_sequencer with a small
// calc1 responder model.
module tb_calc1_req_sequencer;

  logic        c_clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [0:3]  req_cmd;
  logic [0:31] req_op1;
  logic [0:31] req_op2;
  logic [0:3]  cmd_in;
  logic [0:31] data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:1]  rsp_code;
  logic [0:31] rsp_data;
  logic        busy;
  logic        tmo_err;

  int checks = 0;
  int errors = 0;

  // calc1 model state
  int          m_delay = 2;
  logic [1:0]  m_code  = 2'd1;
  logic        m_phase = 1'b0;
  logic        m_active = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_op1 = '0;
  logic [31:0] m_op2 = '0;

  calc1_req_sequencer dut (
    .c_clk     (c_clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .cmd_in    (cmd_in),
    .data_in   (data_in),
    .out_resp  (out_resp),
    .out_data  (out_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_code  (rsp_code),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tmo_err   (tmo_err)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // calc1 responder: answers m_delay cycles after operand 2
  always @(negedge c_clk) begin
    out_resp = 2'd0;
    out_data = '0;
    if (m_active) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == m_delay) begin
        out_resp = m_code;
        out_data = m_op1 + m_op2;
        m_active = 1'b0;
      end
    end else if (m_phase) begin
      m_op2    = data_in;
      m_phase  = 1'b0;
      m_active = (m_delay != 0);
      m_cnt    = 0;
    end
    if (cmd_in != 4'd0) begin
      m_op1   = data_in;
      m_phase = 1'b1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c,
                      input logic [31:0] a,
                      input logic [31:0] b);
    int n;
    req_cmd   = c;
    req_op1   = a;
    req_op2   = b;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    chk("push_rdy", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag,
                         input logic [1:0] c,
                         input logic [31:0] d);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_code"}, 32'(rsp_code), 32'(c));
    chk({tag, "_data"}, rsp_data, d);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_cmd   = '0;
    req_op1   = '0;
    req_op2   = '0;
    rsp_ready = 1'b0;
    out_resp  = '0;
    out_data  = '0;

    // reset state
    tick();
    tick();
    chk("rst_cmd", 32'(cmd_in), 32'd0);
    chk("rst_data", data_in, 32'd0);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(tmo_err), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_rdy", 32'(req_ready), 32'd1);

    // single add with exact cycle sequence
    m_delay = 2;
    m_code  = 2'd1;
    push(4'd1, 32'h1, 32'h2);
    chk("t1_idle_cmd", 32'(cmd_in), 32'd0);
    tick();
    chk("t1_s1_cmd", 32'(cmd_in), 32'd1);
    chk("t1_s1_data", data_in, 32'h1);
    tick();
    chk("t1_s2_cmd", 32'(cmd_in), 32'd0);
    chk("t1_s2_data", data_in, 32'h2);
    tick();
    chk("t1_w_cmd", 32'(cmd_in), 32'd0);
    chk("t1_w_data", data_in, 32'h0);
    chk("t1_w_vld", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    chk("t1_h_vld", 32'(rsp_valid), 32'd1);
    chk("t1_h_code", 32'(rsp_code), 32'd1);
    chk("t1_h_data", rsp_data, 32'h3);
    chk("t1_h_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_done_vld", 32'(rsp_valid), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);

    // walking ones
    for (int k = 0; k < 31; k++) begin
      push(4'd1, 32'd1 << k, 32'd0);
      get_rsp("walk", 2'd1, 32'd1 << k);
    end

    // FIFO full while one op is held
    push(4'd1, 32'h10, 32'h1);
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk("ff_r0_vld", 32'(rsp_valid), 32'd1);
    for (int i = 1; i <= 4; i++)
      push(4'd1, 32'h100 * i, 32'(i));
    chk("ff_full_rdy", 32'(req_ready), 32'd0);
    req_cmd   = 4'd1;
    req_op1   = 32'h500;
    req_op2   = 32'h5;
    req_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("ff_5th_blk", 32'(req_ready), 32'd0);
    chk("ff_r0_code", 32'(rsp_code), 32'd1);
    chk("ff_r0_data", rsp_data, 32'h11);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("ff_pop_rdy", 32'(req_ready), 32'd1);
    chk("ff_b2b_cmd", 32'(cmd_in), 32'd1);
    chk("ff_b2b_data", data_in, 32'h100);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 5; i++)
      get_rsp("ff_ord", 2'd1, 32'h101 * i);
    chk("ff_busy", 32'(busy), 32'd0);

    // response coincides with final timeout cycle
    m_delay = 64;
    m_code  = 2'd2;
    push(4'd1, 32'hFFFF_FFFF, 32'h0);
    tick();
    tick();
    tick();
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk("co_lat", 32'(n), 32'd64);
    get_rsp("co", 2'd2, 32'hFFFF_FFFF);
    chk("co_tmo", 32'(tmo_err), 32'd0);

    // timeout
    m_delay = 0;
    push(4'd1, 32'h5, 32'h6);
    tick();
    chk("to_s1", 32'(cmd_in), 32'd1);
    tick();
    chk("to_s2", data_in, 32'h6);
    tick();
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk("to_lat", 32'(n), 32'd64);
    chk("to_err", 32'(tmo_err), 32'd1);
    get_rsp("to", 2'd0, 32'h0);
    m_delay = 2;
    m_code  = 2'd1;
    push(4'd1, 32'h7, 32'h8);
    get_rsp("to_next", 2'd1, 32'hF);
    chk("to_sticky", 32'(tmo_err), 32'd1);

    // reset in WAIT with two requests queued
    m_delay = 0;
    push(4'd1, 32'hA, 32'h1);
    push(4'd1, 32'hB, 32'h1);
    push(4'd1, 32'hC, 32'h1);
    tick();
    tick();
    tick();
    chk("mr_busy_pre", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_cmd", 32'(cmd_in), 32'd0);
    chk("mr_data", data_in, 32'h0);
    chk("mr_vld", 32'(rsp_valid), 32'd0);
    chk("mr_code", 32'(rsp_code), 32'd0);
    chk("mr_rdata", rsp_data, 32'h0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_tmo", 32'(tmo_err), 32'd0);
    chk("mr_rdy", 32'(req_ready), 32'd1);
    tick();
    m_active = 1'b0;
    m_phase  = 1'b0;
    reset_n  = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (rsp_valid || busy) seen++;
    end
    chk("mr_stale", 32'(seen), 32'd0);
    chk("mr_rdy_post", 32'(req_ready), 32'd1);
    m_delay = 2;
    push(4'd1, 32'h20, 32'h22);
    get_rsp("mr_next", 2'd1, 32'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc1_req_sequencer.md
Name: calc1_req_sequencer

Overview:
- Upstream driver for the calc1 adder port. Buffers whole operation requests (cmd, operand1, operand2) in a small FIFO.
- Serialises each request onto calc1's two-cycle cmd/data input protocol, then waits for calc1's response or a timeout.
- Returns result code and data to the requester over a valid/ready channel.
- Exactly one operation is outstanding at calc1 at any time.

Parameters:
- FIFO_DEPTH, 4: request FIFO entries; power of two, ≥2.
- TIMEOUT, 64: cycles to wait for a calc1 response before aborting.
- TMO_W, 7: width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT.

Ports:
- c_clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept a request; equals !full.
- req_cmd  in  [0:3]  calc1 command; passed through unchecked.
- req_op1  in  [0:31]  first operand.
- req_op2  in  [0:31]  second operand.
- cmd_in  out  [0:3]  command to calc1.
- data_in  out  [0:31]  operand bus to calc1.
- out_resp  in  [0:1]  calc1 response: 0 none, 1 ok, 2 overflow/underflow, 3 invalid cmd.
- out_data  in  [0:31]  calc1 result.
- rsp_valid  out  1  response held for the requester.
- rsp_ready  in  1  requester accepts the response.
- rsp_code  out  [0:1]  out_resp value captured from calc1, or 0 on timeout.
- rsp_data  out  [0:31]  out_data captured from calc1, or 0 on timeout.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- tmo_err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Bit 0 is the MSB on every bus.
- Reset (async assert, sync release):
  - FIFO empty, FSM IDLE.
  - cmd_in=0, data_in=0.
  - rsp_valid=0, rsp_code=0, rsp_data=0.
  - tmo_err=0, busy=0.
  - req_ready=1 from the first cycle after release.
- Reset mid-operation aborts everything: the in-flight op and all queued requests are discarded; no response is produced.
- FIFO:
  - Write when req_valid & req_ready.
  - Pop only on FSM entry to SEND1; the popped entry is latched into cur_cmd/cur_op1/cur_op2.
  - No write bypass. With the FIFO full, a same-cycle pop does not raise req_ready until the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- FSM:
  - IDLE: go to SEND1 when the FIFO is non-empty.
  - SEND1 (1 cycle): cmd_in=cur_cmd, data_in=cur_op1. Go to SEND2.
  - SEND2 (1 cycle): cmd_in=0, data_in=cur_op2. Clear the timeout counter. Go to WAIT.
  - WAIT: cmd_in=0, data_in=0; the counter increments each cycle.
    - If out_resp != 0: capture out_resp/out_data into rsp_code/rsp_data. Go to HOLD.
    - Else if the counter reaches TIMEOUT-1: rsp_code=0, rsp_data=0, set tmo_err. Go to HOLD.
    - A response and the timeout in the same cycle: the response wins and tmo_err is not set.
  - HOLD: rsp_valid=1; rsp_code/rsp_data stable until accepted.
    - On rsp_ready, go to SEND1 (pop) if the FIFO is non-empty, else IDLE.
- Outputs are driven only in SEND1/SEND2; cmd_in and data_in are 0 in all other states.
- out_resp != 0 outside WAIT is ignored and has no side effect.
- Latency:
  - Request written at edge N into an empty FIFO with FSM IDLE: SEND1 is active in the cycle after edge N+1.
  - A calc1 response sampled at edge M: rsp_valid=1 in the cycle after edge M.
- Back-to-back ops: HOLD→SEND1 on the accept edge; no IDLE bubble.
- Requests are serviced strictly in FIFO order; one response per accepted request.

Test Plan:
- Single add, cmd=1, op1=0x00000001, op2=0x00000002; model responds out_resp=1, out_data=3 two cycles after SEND2.
  -> cmd_in/data_in sequence: (1,0x1), (0,0x2), then 0s.
  -> rsp_valid with code 1, data 0x3.
  -> busy drops after accept.
- Walking-ones add: 31 requests cmd=1, op1=1<<k, op2=0, model returns op1+op2.
  -> 31 in-order responses, rsp_data=1<<k, code 1.
- FIFO full: hold rsp_ready=0, push 4 requests plus a 5th.
  -> req_ready=0 after the 4th write; 5th not accepted.
  -> After the first rsp accept, req_ready=1 the cycle after the next pop.
  -> All 5 responses delivered in order.
- Timeout: model never responds, TIMEOUT=64.
  -> Response code 0, data 0, exactly 64 cycles after WAIT entry.
  -> tmo_err=1 and stays set; the next request completes normally.
- Response coincident with the final timeout cycle: code 2, data 0xFFFFFFFF.
  -> rsp_code=2, tmo_err remains 0.
- Reset asserted in WAIT with 2 requests queued.
  -> All outputs 0 immediately (async), FIFO empty.
  -> After release: no stale response, req_ready=1.
